// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        ERR       = 2'd3
    } arb_state_e;

    // Same mask the LSU uses for its own alignment check.
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester ports (LSU = m0, auxiliary = m1) and the data-memory port.
interface mem_port_arbiter_if;

    logic        m0_req_i;
    logic        m0_we_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_wdata_i;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic [31:0] m0_rdata_o;
    logic        m0_err_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic [31:0] m1_rdata_o;
    logic        m1_err_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    // slave: the arbiter side
    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    // master: requesters plus memory, as seen from outside the arbiter
    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the port that did not own last wins.
module rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    output logic o_valid,
    output logic o_winner
);

    assign o_valid  = i_req0 | i_req1;
    assign o_winner = (i_req0 & i_req1) ? ~i_last_owner : i_req1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between LSU (port 0) and an auxiliary master
// (port 1): round-robin, one transaction outstanding, alignment check, timeout.
//
//   state     | meaning
//   IDLE      | arbitrate and latch the winner's request
//   ISSUE     | mem_req_o high until the memory grants
//   WAIT_RESP | waiting for mem_rvalid_i
//   ERR       | one-cycle misaligned-address completion
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_e    r_state;
    arb_state_e    w_next_state;
    logic          r_owner;
    logic          r_last_owner;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic          r_rsp_gnt;
    logic [31:0]   r_rdata;

    logic          w_pick_valid;
    logic          w_pick_winner;
    logic          w_sel_we;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic          w_mem_req;
    logic          w_timeout;
    logic          w_issue_gnt;
    logic          w_err_cycle;
    logic          w_gnt;
    logic          w_rvalid;
    logic          w_err;

    rr_pick2 u_pick (
        .i_req0       (bus.m0_req_i),
        .i_req1       (bus.m1_req_i),
        .i_last_owner (r_last_owner),
        .o_valid      (w_pick_valid),
        .o_winner     (w_pick_winner)
    );

    assign w_sel_we    = w_pick_winner ? bus.m1_we_i    : bus.m0_we_i;
    assign w_sel_addr  = w_pick_winner ? bus.m1_addr_i  : bus.m0_addr_i;
    assign w_sel_wdata = w_pick_winner ? bus.m1_wdata_i : bus.m0_wdata_i;

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid)
                    w_next_state = is_misaligned(w_sel_addr[1:0]) ? ERR : ISSUE;
            end
            ISSUE: begin
                w_mem_req = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end else if (bus.mem_gnt_i) begin
                    w_next_state = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (bus.mem_rvalid_i) begin
                    w_next_state = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            ERR:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_gnt    <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_gnt   <= 1'b0;
            r_rdata     <= '0;
            if (r_state == IDLE && w_pick_valid) begin
                r_owner      <= w_pick_winner;
                r_last_owner <= w_pick_winner;
                r_we         <= w_sel_we;
                r_addr       <= w_sel_addr;
                r_wdata      <= w_sel_wdata;
                r_cnt        <= '0;
            end
            if ((r_state == ISSUE || r_state == WAIT_RESP) && r_cnt != CNT_LAST)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == WAIT_RESP && bus.mem_rvalid_i) begin
                r_rsp_valid <= 1'b1;
                r_rdata     <= r_we ? 32'd0 : bus.mem_rdata_i;
            end
            // A timeout in ISSUE never produced a grant, so it is given with the error.
            if (w_timeout) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_gnt   <= (r_state == ISSUE);
            end
        end
    end

    assign w_issue_gnt = (r_state == ISSUE) && bus.mem_gnt_i && !w_timeout;
    assign w_err_cycle = (r_state == ERR);
    assign w_gnt       = w_issue_gnt | w_err_cycle | r_rsp_gnt;
    assign w_rvalid    = w_err_cycle | r_rsp_valid;
    assign w_err       = w_err_cycle | r_rsp_err;

    // r_owner only changes at the end of the response cycle, so routing by it is safe.
    assign bus.m0_gnt_o    = ~r_owner & w_gnt;
    assign bus.m0_rvalid_o = ~r_owner & w_rvalid;
    assign bus.m0_err_o    = ~r_owner & w_err;
    assign bus.m0_rdata_o  = r_owner ? 32'd0 : r_rdata;
    assign bus.m1_gnt_o    = r_owner & w_gnt;
    assign bus.m1_rvalid_o = r_owner & w_rvalid;
    assign bus.m1_err_o    = r_owner & w_err;
    assign bus.m1_rdata_o  = r_owner ? r_rdata : 32'd0;

    assign bus.mem_req_o   = w_mem_req;
    assign bus.mem_we_o    = w_mem_req & r_we;
    assign bus.mem_addr_o  = w_mem_req ? r_addr  : 32'd0;
    assign bus.mem_wdata_o = w_mem_req ? r_wdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of mem_port_arbiter with TIMEOUT_CYCLES = 4.
module tb_mem_port_arbiter;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        bus.m0_req_i = 0; bus.m0_we_i = 0; bus.m0_addr_i = 0; bus.m0_wdata_i = 0;
        bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_addr_i = 0; bus.m1_wdata_i = 0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk_eq({tag, ".m0_gnt"},    bus.m0_gnt_o,    0);
        chk_eq({tag, ".m0_rvalid"}, bus.m0_rvalid_o, 0);
        chk_eq({tag, ".m1_gnt"},    bus.m1_gnt_o,    0);
        chk_eq({tag, ".m1_rvalid"}, bus.m1_rvalid_o, 0);
        chk_eq({tag, ".mem_req"},   bus.mem_req_o,   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_inputs();
        reset = 1'b1;
        do_reset();
        settle();
        chk_quiet("reset");
        chk_eq("reset.m0_err", bus.m0_err_o, 0);
        chk_eq("reset.m1_rdata", bus.m1_rdata_o, 0);

        // best-case port 0 load
        next_cycle();
        bus.m0_req_i = 1; bus.m0_we_i = 0; bus.m0_addr_i = 32'h100;
        settle();
        chk_eq("ld.c0.mem_req", bus.mem_req_o, 0);
        next_cycle();
        bus.mem_gnt_i = 1;
        settle();
        chk_eq("ld.c1.mem_req", bus.mem_req_o, 1);
        chk_eq("ld.c1.mem_addr", bus.mem_addr_o, 32'h100);
        chk_eq("ld.c1.m0_gnt", bus.m0_gnt_o, 1);
        chk_eq("ld.c1.m1_gnt", bus.m1_gnt_o, 0);
        next_cycle();
        bus.m0_req_i = 0; bus.mem_gnt_i = 0;
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hDEADBEEF;
        settle();
        chk_eq("ld.c2.mem_req", bus.mem_req_o, 0);
        chk_eq("ld.c2.m0_rvalid", bus.m0_rvalid_o, 0);
        next_cycle();
        bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
        settle();
        chk_eq("ld.c3.m0_rvalid", bus.m0_rvalid_o, 1);
        chk_eq("ld.c3.m0_rdata", bus.m0_rdata_o, 32'hDEADBEEF);
        chk_eq("ld.c3.m0_err", bus.m0_err_o, 0);
        chk_eq("ld.c3.m1_rvalid", bus.m1_rvalid_o, 0);
        chk_eq("ld.c3.m1_rdata", bus.m1_rdata_o, 0);

        // both ports requesting: port 0 loads, port 1 stores, owners alternate
        do_reset();
        bus.m0_req_i = 1; bus.m0_we_i = 0; bus.m0_addr_i = 32'h200;
        bus.m1_req_i = 1; bus.m1_we_i = 1; bus.m1_addr_i = 32'h300; bus.m1_wdata_i = 32'hCAFE0001;
        settle();
        for (int k = 0; k < 4; k++) begin
            logic exp_owner;
            exp_owner = k[0];
            next_cycle();
            bus.mem_gnt_i = 1;
            settle();
            chk_eq($sformatf("rr%0d.mem_req", k), bus.mem_req_o, 1);
            chk_eq($sformatf("rr%0d.m0_gnt", k), bus.m0_gnt_o, {31'd0, !exp_owner});
            chk_eq($sformatf("rr%0d.m1_gnt", k), bus.m1_gnt_o, {31'd0, exp_owner});
            chk_eq($sformatf("rr%0d.mem_addr", k), bus.mem_addr_o, exp_owner ? 32'h300 : 32'h200);
            chk_eq($sformatf("rr%0d.mem_we", k), bus.mem_we_o, {31'd0, exp_owner});
            next_cycle();
            bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1000 + k;
            settle();
            chk_eq($sformatf("rr%0d.wait.mem_req", k), bus.mem_req_o, 0);
            next_cycle();
            bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
            if (k == 3) begin
                bus.m0_req_i = 0; bus.m1_req_i = 0;
            end
            settle();
            chk_eq($sformatf("rr%0d.rsp.mem_req", k), bus.mem_req_o, 0);
            chk_eq($sformatf("rr%0d.m0_rvalid", k), bus.m0_rvalid_o, {31'd0, !exp_owner});
            chk_eq($sformatf("rr%0d.m1_rvalid", k), bus.m1_rvalid_o, {31'd0, exp_owner});
            chk_eq($sformatf("rr%0d.m0_rdata", k), bus.m0_rdata_o, exp_owner ? 32'd0 : 32'h1000 + k);
            chk_eq($sformatf("rr%0d.m1_rdata", k), bus.m1_rdata_o, 0);
        end

        // misaligned port 1 store
        next_cycle();
        bus.m1_req_i = 1; bus.m1_we_i = 1; bus.m1_addr_i = 32'h102; bus.m1_wdata_i = 32'h55;
        settle();
        chk_eq("mis.c0.mem_req", bus.mem_req_o, 0);
        next_cycle();
        settle();
        chk_eq("mis.c1.mem_req", bus.mem_req_o, 0);
        chk_eq("mis.c1.m1_gnt", bus.m1_gnt_o, 1);
        chk_eq("mis.c1.m1_rvalid", bus.m1_rvalid_o, 1);
        chk_eq("mis.c1.m1_err", bus.m1_err_o, 1);
        chk_eq("mis.c1.m1_rdata", bus.m1_rdata_o, 0);
        chk_eq("mis.c1.m0_gnt", bus.m0_gnt_o, 0);
        next_cycle();
        bus.m1_req_i = 0;
        settle();
        chk_quiet("mis.c2");
        chk_eq("mis.c2.m1_err", bus.m1_err_o, 0);

        // granted but never answered: error rvalid 4 cycles after ISSUE entry
        next_cycle();
        bus.m0_req_i = 1; bus.m0_we_i = 0; bus.m0_addr_i = 32'h400;
        settle();
        next_cycle();
        bus.mem_gnt_i = 1;
        settle();
        chk_eq("tow.c1.m0_gnt", bus.m0_gnt_o, 1);
        for (int c = 2; c <= 4; c++) begin
            next_cycle();
            bus.m0_req_i = 0; bus.mem_gnt_i = 0;
            settle();
            chk_eq($sformatf("tow.c%0d.m0_rvalid", c), bus.m0_rvalid_o, 0);
            chk_eq($sformatf("tow.c%0d.mem_req", c), bus.mem_req_o, 0);
        end
        next_cycle();
        settle();
        chk_eq("tow.c5.m0_rvalid", bus.m0_rvalid_o, 1);
        chk_eq("tow.c5.m0_err", bus.m0_err_o, 1);
        chk_eq("tow.c5.m0_gnt", bus.m0_gnt_o, 0);
        chk_eq("tow.c5.m0_rdata", bus.m0_rdata_o, 0);
        next_cycle();
        next_cycle();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hFFFF_0000;
        settle();
        chk_quiet("tow.c7");
        next_cycle();
        bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
        settle();
        chk_quiet("tow.c8");
        chk_eq("tow.c8.m0_rdata", bus.m0_rdata_o, 0);

        // memory never grants
        next_cycle();
        bus.m1_req_i = 1; bus.m1_we_i = 0; bus.m1_addr_i = 32'h500;
        settle();
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            settle();
            chk_eq($sformatf("tog.c%0d.mem_req", c), bus.mem_req_o, 1);
            chk_eq($sformatf("tog.c%0d.m1_gnt", c), bus.m1_gnt_o, 0);
        end
        next_cycle();
        bus.m1_req_i = 0;
        settle();
        chk_eq("tog.c5.mem_req", bus.mem_req_o, 0);
        chk_eq("tog.c5.m1_gnt", bus.m1_gnt_o, 1);
        chk_eq("tog.c5.m1_rvalid", bus.m1_rvalid_o, 1);
        chk_eq("tog.c5.m1_err", bus.m1_err_o, 1);
        chk_eq("tog.c5.m0_rvalid", bus.m0_rvalid_o, 0);
        next_cycle();
        settle();
        chk_quiet("tog.c6");

        // reset during WAIT_RESP, then a stray response and a fresh port 1 load
        next_cycle();
        bus.m0_req_i = 1; bus.m0_we_i = 0; bus.m0_addr_i = 32'h600;
        settle();
        next_cycle();
        bus.mem_gnt_i = 1;
        settle();
        chk_eq("rst.c1.m0_gnt", bus.m0_gnt_o, 1);
        next_cycle();
        bus.m0_req_i = 0; bus.mem_gnt_i = 0;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        settle();
        chk_quiet("rst.c4");
        next_cycle();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0000_0BAD;
        settle();
        chk_quiet("rst.c5");
        next_cycle();
        bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
        bus.m1_req_i = 1; bus.m1_we_i = 0; bus.m1_addr_i = 32'h700;
        settle();
        chk_quiet("rst.c6");
        chk_eq("rst.c6.m0_rdata", bus.m0_rdata_o, 0);
        next_cycle();
        bus.mem_gnt_i = 1;
        settle();
        chk_eq("rst.c7.mem_req", bus.mem_req_o, 1);
        chk_eq("rst.c7.mem_addr", bus.mem_addr_o, 32'h700);
        chk_eq("rst.c7.m1_gnt", bus.m1_gnt_o, 1);
        next_cycle();
        bus.m1_req_i = 0; bus.mem_gnt_i = 0;
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1234_5678;
        settle();
        next_cycle();
        bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
        settle();
        chk_eq("rst.c9.m1_rvalid", bus.m1_rvalid_o, 1);
        chk_eq("rst.c9.m1_rdata", bus.m1_rdata_o, 32'h1234_5678);
        chk_eq("rst.c9.m1_err", bus.m1_err_o, 0);
        chk_eq("rst.c9.m0_rvalid", bus.m0_rvalid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-memory port between two requesters: port 0 is the LSU, port 1 is an auxiliary master (debug/loader). It arbitrates round-robin and sequences each access through a grant/response handshake. It rejects word-misaligned addresses without touching memory, and it bounds every memory transaction with a timeout. It sits between the LSU and the data-memory interface, with one transaction outstanding at a time.

## Interface
- `TIMEOUT_CYCLES`, default 16: the maximum number of cycles a transaction may spend in ISSUE plus WAIT_RESP before it is aborted with an error; the minimum legal value is 2.
- `clock`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mN_req_i`  in  1  request from port N (N = 0, 1); held high until `mN_gnt_o`.
- `mN_we_i`  in  1  1 selects a store, 0 selects a load.
- `mN_addr_i`  in  32  byte address.
- `mN_wdata_i`  in  32  store data.
- `mN_gnt_o`  out  1  one-cycle pulse: the request is accepted, and the requester may drop or change its inputs.
- `mN_rvalid_o`  out  1  one-cycle pulse: the transaction is complete.
- `mN_rdata_o`  out  32  load data, valid with `mN_rvalid_o`; 0 otherwise.
- `mN_err_o`  out  1  qualifies `mN_rvalid_o`: misaligned address or timeout.
- `mem_req_o`  out  1  request to the memory.
- `mem_we_o`  out  1  write enable to the memory.
- `mem_addr_o`  out  32  address to the memory.
- `mem_wdata_o`  out  32  write data to the memory.
- `mem_gnt_i`  in  1  the memory accepts the current request.
- `mem_rvalid_i`  in  1  response from the memory; given for both loads and stores.
- `mem_rdata_i`  in  32  read data from the memory.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP, ERR.
- IDLE:
  - If no `mN_req_i` is high, stay in IDLE.
  - Otherwise pick the winner. When both ports request, the port that was not the last owner wins.
  - Latch the winner's owner id, `we`, `addr` and `wdata`, and update the last-owner register.
  - If `addr[1:0] != 0`, go to ERR; otherwise go to ISSUE.
- ISSUE:
  - `mem_req_o` = 1, and the memory outputs are driven from the latched fields.
  - When `mem_gnt_i` = 1, the owner's `gnt_o` pulses in the same cycle (combinational from `mem_gnt_i`) and the FSM goes to WAIT_RESP.
- WAIT_RESP:
  - `mem_req_o` = 0.
  - When `mem_rvalid_i` = 1, register `mem_rdata_i` into the owner's `rdata_o` (forced to 0 for stores) and pulse the owner's `rvalid_o` in the next cycle. That next cycle is IDLE.
- ERR, lasting one cycle:
  - The owner's `gnt_o`, `rvalid_o` and `err_o` are all 1, and `rdata_o` = 0. No memory request is made.
  - Next state is IDLE.
- Timeout:
  - A counter is cleared on entry to ISSUE and counts every cycle spent in ISSUE or WAIT_RESP.
  - When the count reaches `TIMEOUT_CYCLES`-1 with no completion, the next cycle is IDLE and the owner gets `rvalid_o` = 1, `err_o` = 1, `rdata_o` = 0.
  - If the timeout fires in ISSUE, the owner also gets `gnt_o` = 1 in that cycle, and `mem_req_o` drops.
- Ports never receive each other's outputs. The non-owner's outputs stay at 0 throughout.
- A `mem_rvalid_i` arriving in IDLE, ISSUE or ERR is a stray or late response; it is ignored and produces no output.

## Timing
- Reset values:
  - State = IDLE.
  - Last-owner = 1, so port 0 wins the first tie.
  - Counter = 0.
  - All `*_o` = 0.
- Best-case load:
  - Request seen in IDLE at cycle 0.
  - `mem_req_o` rises at cycle 1, `mem_gnt_i` arrives at cycle 1, and `gnt_o` pulses at cycle 1.
  - `mem_rvalid_i` arrives at cycle 2, and `rvalid_o`/`rdata_o` appear at cycle 3.
- Back-to-back throughput: the next arbitration happens in the cycle that `rvalid_o` is asserted, so the next `mem_req_o` rises one cycle later. That is one transaction per 3 cycles at best.
- A misaligned request completes with a single ERR cycle, one cycle after it is sampled.
- Simultaneous events:
  - The cycle `rvalid_o` is asserted is IDLE, so a pending request is arbitrated in that same cycle.
  - `mem_gnt_i` and `mem_rvalid_i` asserted together in ISSUE: only the grant is honoured.
- Reset mid-transaction: the FSM returns to IDLE, the outstanding access is dropped with no `rvalid_o`, and a later `mem_rvalid_i` is ignored.
- Width: the counter is $clog2(`TIMEOUT_CYCLES`) bits and saturates; it never wraps.

## Structure
- `CORE_PKG` gains:
  - an `arb_state_e` enum {IDLE, ISSUE, WAIT_RESP, ERR};
  - a `WORD_ALIGN_MASK` = 2'b11 constant, shared with the LSU's alignment check.
- One sub-module, `rr_pick2`: a combinational two-way round-robin pick of `{req0, req1, last_owner}` that outputs `{valid, winner}`.
- FSM, latches and counter live in `mem_port_arbiter`.

## Test plan
- Port 0 load at 0x100, memory grants immediately and returns 0xDEADBEEF one cycle later → `m0_gnt_o` at cycle 1, `m0_rvalid_o` with `m0_rdata_o` = 0xDEADBEEF at cycle 3, and port 1 outputs stay 0.
- Both ports hold requests for 4 transactions → owners alternate 0,1,0,1 (port 0 first after reset), and there are never two `mem_req_o` without an intervening `mem_rvalid_i`.
- Port 1 store at 0x102 → ERR cycle with `m1_gnt_o`, `m1_rvalid_o` and `m1_err_o` = 1, and `mem_req_o` never asserted.
- `TIMEOUT_CYCLES` = 4 and the memory grants but never responds → error `rvalid_o` 4 cycles after ISSUE entry; a `mem_rvalid_i` injected 2 cycles later is ignored.
- Memory never grants → after 4 cycles `mem_req_o` drops and the owner sees `gnt_o`, `rvalid_o` and `err_o` together.
- Reset asserted in WAIT_RESP, then `mem_rvalid_i` after release → all outputs 0 and FSM in IDLE; the stray response is ignored and a fresh port 1 request is served normally.
